// File: rtl/dsp_pkg.sv
// Shared DSP definitions: instruction format, opcodes and field widths.
// Imported by the sequencer and by dsp_core.
package dsp_pkg;

    localparam int OPCODE_WIDTH       = 6;
    localparam int SAMPLE_ADDR_WIDTH  = 10;
    localparam int PARAM_ADDR_WIDTH   = 10;
    localparam int INSTR_WIDTH        = OPCODE_WIDTH + SAMPLE_ADDR_WIDTH + PARAM_ADDR_WIDTH;
    localparam int PC_WIDTH           = 10;
    localparam int DEFAULT_PIPE_DEPTH = 4;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP   = 6'd0,
        OP_LOAD  = 6'd1,
        OP_MAC   = 6'd2,
        OP_STORE = 6'd3,
        OP_SPIN  = 6'd4
    } opcode_t;

    typedef struct packed {
        opcode_t                      opcode;
        logic [SAMPLE_ADDR_WIDTH-1:0] sample_addr;
        logic [PARAM_ADDR_WIDTH-1:0]  param_addr;
    } instr_t;

    localparam instr_t NOP_INSTR = '0;

endpackage

// File: rtl/dsp_sequencer.sv
// Per-frame instruction sequencer: on each accepted sample tick streams the
// program from instruction RAM into dsp_core, then pads with NOPs until the core drains.
module dsp_sequencer
    import dsp_pkg::*;
#(
    parameter int PIPE_DEPTH = DEFAULT_PIPE_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sample_tick,
    input  logic [PC_WIDTH:0]      prog_len,
    output logic [PC_WIDTH-1:0]    imem_rd_addr,
    output logic                   imem_rd_en,
    input  logic [INSTR_WIDTH-1:0] imem_rd_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam int DRAIN_W = $clog2(PIPE_DEPTH + 1);
    localparam logic [PC_WIDTH:0]      MAX_LEN  = {1'b1, {PC_WIDTH{1'b0}}};
    localparam logic [INSTR_WIDTH-1:0] NOP_BITS = NOP_INSTR;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [PC_WIDTH:0]    len_q, len_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 overrun_q, overrun_d;
    logic                 fetch_valid_q;
    logic                 accept;
    logic [PC_WIDTH:0]    clamped_len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            len_q         <= '0;
            drain_q       <= '0;
            overrun_q     <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            len_q         <= len_d;
            drain_q       <= drain_d;
            overrun_q     <= overrun_d;
            fetch_valid_q <= imem_rd_en;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        len_d        = len_q;
        drain_d      = drain_q;
        overrun_d    = overrun_q;
        imem_rd_en   = 1'b0;
        imem_rd_addr = '0;
        frame_done   = 1'b0;
        busy         = (state_q != IDLE);
        accept       = 1'b0;
        clamped_len  = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;

        unique case (state_q)
            IDLE: begin
                accept = sample_tick;
            end
            RUN: begin
                imem_rd_en   = 1'b1;
                imem_rd_addr = pc_q;
                pc_d         = pc_q + 1'b1;
                if ({1'b0, pc_q} == len_q - 1'b1) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_W'(PIPE_DEPTH);
                end
            end
            // One cycle beyond PIPE_DEPTH: the last instruction reaches the core a cycle after its read.
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
                accept     = sample_tick;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            len_d   = clamped_len;
            pc_d    = '0;
            state_d = (clamped_len != '0) ? RUN : DONE;
        end

        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (sample_tick && (state_q == RUN || state_q == DRAIN)) begin
            overrun_d = 1'b1;
        end
    end

    assign instruction = fetch_valid_q ? imem_rd_data : NOP_BITS;
    assign overrun     = overrun_q;

endmodule
